// File: rtl/ws2812b_decoder_if.sv
// Pixel stream bus out of the WS2812B decoder: 24-bit pixel with valid/ready.
interface ws2812b_decoder_if;
    logic [23:0] data_out;
    logic        valid;
    logic        ready;

    modport master (output data_out, valid, input ready);
    modport slave  (input data_out, valid, output ready);
endinterface

// File: rtl/ws2812b_decoder.sv
// WS2812B receive decoder: synchronizes the raw LED line, classifies high
// pulse widths into bits, assembles MSB-first 24-bit pixels onto a valid/ready
// stream and flags latch gaps, malformed pulses and overruns.
// Optional feature macro: WS2812B_DECODER_FORWARD_EN (forward the line on
// led_out after the first pixel of each frame has been consumed locally).
module ws2812b_decoder #(
    parameter int THRESH_CYCLES   = 12,
    parameter int MIN_HIGH_CYCLES = 3,
    parameter int MAX_HIGH_CYCLES = 40,
    parameter int LATCH_CYCLES    = 1000
) (
    input  logic                   clk20,
    input  logic                   reset,
    input  logic                   din,
    ws2812b_decoder_if.master      pix,
    output logic                   latch,
    output logic                   error,
    output logic                   overrun,
    output logic [8:0]             pixel_count,
    output logic                   led_out
);
    // hcnt saturates at MAX_HIGH_CYCLES+1 so over-long pulses stay distinguishable
    localparam int HW = $clog2(MAX_HIGH_CYCLES + 2);
    localparam int LW = $clog2(LATCH_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} state_t;

    state_t          state, state_nxt;
    logic            s1, s2, s3;
    logic            rise, fall;
    logic [HW-1:0]   hcnt, hcnt_nxt;
    logic [LW-1:0]   lcnt, lcnt_nxt;
    logic [23:0]     shreg;
    logic [23:0]     shift_nxt;
    logic [4:0]      bitcnt;
    logic            armed;
    logic            take_bit, long_err, gap_done, lat_fire, lat_err;
    logic            bit_val;

    assign rise      = s2 & ~s3;
    assign fall      = ~s2 & s3;
    assign bit_val   = (hcnt >= HW'(THRESH_CYCLES));
    assign shift_nxt = {shreg[22:0], bit_val};

    // two-flop synchronizer on the asynchronous line, plus one delay for edges
    always_ff @(posedge clk20 or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // FSM state and pulse-width counters
    always_ff @(posedge clk20 or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            hcnt  <= '0;
            lcnt  <= '0;
        end else begin
            state <= state_nxt;
            hcnt  <= hcnt_nxt;
            lcnt  <= lcnt_nxt;
        end
    end

    // next state, counter updates and per-cycle decode strobes
    always_comb begin
        state_nxt = state;
        hcnt_nxt  = hcnt;
        lcnt_nxt  = lcnt;
        take_bit  = 1'b0;
        long_err  = 1'b0;
        gap_done  = 1'b0;
        lat_fire  = 1'b0;
        lat_err   = 1'b0;
        case (state)
            S_IDLE: begin
                if (rise) begin
                    state_nxt = S_HIGH;
                    hcnt_nxt  = HW'(1);
                end
            end
            S_HIGH: begin
                if (fall) begin
                    state_nxt = S_LOW;
                    lcnt_nxt  = '0;
                    if (hcnt > HW'(MAX_HIGH_CYCLES))
                        long_err = 1'b1;
                    else if (hcnt >= HW'(MIN_HIGH_CYCLES))
                        take_bit = 1'b1;
                end else if (hcnt <= HW'(MAX_HIGH_CYCLES)) begin
                    hcnt_nxt = hcnt + HW'(1);
                end
            end
            S_LOW: begin
                if (rise) begin
                    state_nxt = S_HIGH;
                    hcnt_nxt  = HW'(1);
                    lcnt_nxt  = '0;
                end else if (lcnt == LW'(LATCH_CYCLES - 1)) begin
                    // gap reached: only a line that carried bits reports a latch
                    state_nxt = S_IDLE;
                    lcnt_nxt  = '0;
                    gap_done  = 1'b1;
                    lat_fire  = armed;
                    lat_err   = (bitcnt != 5'd0);
                end else begin
                    lcnt_nxt = lcnt + LW'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // bit assembly, pixel hand-off, handshake and status pulses
    always_ff @(posedge clk20 or posedge reset) begin
        if (reset) begin
            shreg        <= '0;
            bitcnt       <= '0;
            armed        <= 1'b0;
            pixel_count  <= '0;
            pix.data_out <= '0;
            pix.valid    <= 1'b0;
            latch        <= 1'b0;
            error        <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            latch   <= lat_fire;
            error   <= long_err | lat_err;
            overrun <= 1'b0;
            if (pix.valid && pix.ready)
                pix.valid <= 1'b0;
            if (long_err) begin
                shreg  <= '0;
                bitcnt <= '0;
            end
            if (take_bit) begin
                armed <= 1'b1;
                shreg <= shift_nxt;
                if (bitcnt == 5'd23) begin
                    bitcnt <= '0;
                    if (pixel_count != 9'd511)
                        pixel_count <= pixel_count + 9'd1;
                    // a consumer taking the held pixel this cycle frees the slot
                    if (!pix.valid || pix.ready) begin
                        pix.data_out <= shift_nxt;
                        pix.valid    <= 1'b1;
                    end else begin
                        overrun <= 1'b1;
                    end
                end else begin
                    bitcnt <= bitcnt + 5'd1;
                end
            end
            if (gap_done) begin
                bitcnt      <= '0;
                pixel_count <= '0;
                armed       <= 1'b0;
            end
        end
    end

`ifdef WS2812B_DECODER_FORWARD_EN
    logic fwd;

    // forwarding opens once the first pixel of a frame is taken, closes at latch
    always_ff @(posedge clk20 or posedge reset) begin
        if (reset)
            fwd <= 1'b0;
        else if (gap_done)
            fwd <= 1'b0;
        else if (take_bit && bitcnt == 5'd23)
            fwd <= 1'b1;
    end

    assign led_out = fwd & s2;
`else
    assign led_out = 1'b0;
`endif

endmodule
